// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store requests turned into 64-bit big-endian
// doubleword cycles on a byte-addressed data memory. Sub-doubleword stores
// are read-modify-write. One request in flight; all outputs are registered.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned requests.
module load_store_unit #(
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddr,
    input  logic [63:0] ReqWData,
    output logic        RespValid,
    output logic [63:0] RespData,
    output logic        RespError,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    output logic [63:0] Address,
    output logic [63:0] WriteData,
    input  logic [63:0] ReadData
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, RESP
    } state_t;

    state_t      state, state_next;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic [63:0] data_q;
    logic [2:0]  wait_cnt;

    logic        accept;
    logic        range_ok;
    logic        aligned;
    logic        req_ok;
    logic        wait_done;
    logic [63:0] load_value;
    logic [63:0] merged;

    // Pull the top 1/2/4/8 bytes out of a big-endian doubleword and extend.
    function automatic logic [63:0] extract(input logic [63:0] d, input logic [1:0] size,
                                            input logic sgn);
        logic [63:0] r;
        case (size)
            2'b00:   r = sgn ? {{56{d[63]}}, d[63:56]} : {56'd0, d[63:56]};
            2'b01:   r = sgn ? {{48{d[63]}}, d[63:48]} : {48'd0, d[63:48]};
            2'b10:   r = sgn ? {{32{d[63]}}, d[63:32]} : {32'd0, d[63:32]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Overwrite the top N bytes of the old doubleword with the low N store bytes.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [1:0] size);
        logic [63:0] r;
        case (size)
            2'b00:   r = {wd[7:0],  old[55:0]};
            2'b01:   r = {wd[15:0], old[47:0]};
            2'b10:   r = {wd[31:0], old[31:0]};
            default: r = wd;
        endcase
        return r;
    endfunction

    assign accept     = ReqValid && ReqReady && (state == IDLE);
    assign wait_done  = (state == RD_WAIT) && (wait_cnt == 3'd0);
    assign load_value = extract(ReadData, req_size, req_signed);
    assign merged     = merge(data_q, req_wdata, req_size);

    // Legality of the incoming request: 65-bit range sum, optional alignment.
    always_comb begin
        range_ok = (({1'b0, ReqAddr} + 65'd7) < 65'(MEM_BYTES));
        aligned  = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        case (ReqSize)
            2'b01:   aligned = (ReqAddr[0] == 1'b0);
            2'b10:   aligned = (ReqAddr[1:0] == 2'b00);
            2'b11:   aligned = (ReqAddr[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
`endif
        req_ok = range_ok && aligned;
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_ok)                              state_next = RESP;
                    else if (ReqWrite && (ReqSize == 2'b11))  state_next = WR_ISSUE;
                    else                                      state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  if (wait_cnt == 3'd0) state_next = req_write ? MERGE : RESP;
            MERGE:    state_next = WR_ISSUE;
            WR_ISSUE: state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Request latch, read capture, wait counter and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ReqReady    <= 1'b1;
            RespValid   <= 1'b0;
            RespData    <= 64'd0;
            RespError   <= 1'b0;
            MemoryRead  <= 1'b0;
            MemoryWrite <= 1'b0;
            Address     <= 64'd0;
            WriteData   <= 64'd0;
            req_write   <= 1'b0;
            req_size    <= 2'b00;
            req_signed  <= 1'b0;
            req_wdata   <= 64'd0;
            data_q      <= 64'd0;
            wait_cnt    <= 3'd0;
        end else begin
            ReqReady    <= (state_next == IDLE);
            RespValid   <= (state_next == RESP);
            MemoryRead  <= (state_next == RD_ISSUE);
            MemoryWrite <= (state_next == WR_ISSUE);
            RespError   <= accept && !req_ok;
            RespData    <= (wait_done && !req_write) ? load_value : 64'd0;
            WriteData   <= 64'd0;
            if (accept) begin
                req_write  <= ReqWrite;
                req_size   <= ReqSize;
                req_signed <= ReqSigned;
                req_wdata  <= ReqWData;
                Address    <= ReqAddr;
                if (req_ok && ReqWrite && (ReqSize == 2'b11)) WriteData <= ReqWData;
            end else if (state_next == IDLE) begin
                Address <= 64'd0;
            end
            if (state == MERGE) WriteData <= merged;
            if (wait_done) data_q <= ReadData;
            if (state == RD_ISSUE) wait_cnt <= 3'(READ_LATENCY - 1);
            else if ((state == RD_WAIT) && (wait_cnt != 3'd0)) wait_cnt <= wait_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a directed vector table, a
// mid-operation reset sequence, and randomized requests against a
// byte-array reference model. Honours LSU_ALIGN_CHECK_EN if defined.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [63:0] ReqAddr;
    logic [63:0] ReqWData;
    logic        RespValid;
    logic [63:0] RespData;
    logic        RespError;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [63:0] Address;
    logic [63:0] WriteData;
    logic [63:0] ReadData;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem       [1024];
    logic [7:0]  model_mem [1024];
    int          rd_count   = 0;
    int          wr_count   = 0;
    logic [63:0] last_raddr = 64'd0;
    logic [63:0] last_wdata = 64'd0;
    logic        both_seen  = 1'b0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_nr;
        int          exp_nw;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    load_store_unit #(.MEM_BYTES(1024), .READ_LATENCY(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .RespValid(RespValid), .RespData(RespData),
        .RespError(RespError), .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) begin
            v = v << 8;
            if (a < 64'd1017) v = v | 64'(mem[int'(a[9:0]) + i]);
        end
        return v;
    endfunction

    // Data memory with one cycle read latency, plus strobe monitoring.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[8'h18] = 8'h0F; mem[8'h19] = 8'hFB; mem[8'h1A] = 8'hEA; mem[8'h1B] = 8'h7D;
        mem[8'h1C] = 8'hEA; mem[8'h1D] = 8'hDB; mem[8'h1E] = 8'hEE; mem[8'h1F] = 8'hFF;
        mem[8'h0F] = 8'h0A;
        ReadData = 64'd0;
        forever begin
            @(posedge Clk);
            if (MemoryRead && MemoryWrite) both_seen = 1'b1;
            if (MemoryRead) begin
                rd_count++;
                last_raddr = Address;
                ReadData <= mem_read(Address);
            end
            if (MemoryWrite) begin
                wr_count++;
                last_wdata = WriteData;
                if (Address < 64'd1017)
                    for (int i = 0; i < 8; i++) mem[int'(Address[9:0]) + i] = WriteData[63-8*i -: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: legality, latency and memory effect from the access rules.
    function automatic logic model_ok(input logic [1:0] sz, input logic [63:0] a);
        logic ok = (a <= 64'd1016);
`ifdef LSU_ALIGN_CHECK_EN
        if ((a % (64'd1 << sz)) != 64'd0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic sg, input logic [63:0] a);
        int n = 1 << sz;
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(model_mem[int'(a[9:0]) + i]);
        if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) model_mem[int'(a[9:0]) + i] = 8'(wd >> (8*(n-1-i)));
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 output logic [63:0] data, output logic err, output int lat,
                                 output int nr, output int nw);
        int g = 0;
        int r0, w0;
        @(negedge Clk);
        while (!ReqReady && g < 50) begin @(negedge Clk); g++; end
        if (!ReqReady) checkOutput("ready_timeout", {63'd0, ReqReady}, 64'd1);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        r0 = rd_count; w0 = wr_count;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!RespValid && lat < 40);
        if (!RespValid) begin
            checkOutput("resp_timeout", {63'd0, RespValid}, 64'd1);
            lat = -1;
        end
        data = RespData; err = RespError;
        nr = rd_count - r0; nw = wr_count - w0;
        @(negedge Clk);
        checkOutput("ready_after_resp", {62'd0, ReqReady, RespValid}, 64'd2);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [63:0] data;
        logic err;
        int lat, nr, nw;
        applyStimulus(v.w, v.sz, v.sg, v.a, v.wd, data, err, lat, nr, nw);
        checkOutput({tag, "_data"}, data, v.exp_data);
        checkOutput({tag, "_err"}, {63'd0, err}, {63'd0, v.exp_err});
        checkOutput({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
        checkOutput({tag, "_reads"}, 64'(nr), 64'(v.exp_nr));
        checkOutput({tag, "_writes"}, 64'(nw), 64'(v.exp_nw));
        if (v.exp_nr == 1) checkOutput({tag, "_raddr"}, last_raddr, v.a);
        if (v.exp_nw == 1) checkOutput({tag, "_wdata"}, last_wdata, v.exp_wdata);
        if (v.w && !v.exp_err) model_store(v.sz, v.a, v.wd);
    endtask

    initial begin
        logic [63:0] data;
        logic err;
        int lat, nr, nw, w0;

        ReqValid = 0; ReqWrite = 0; ReqSize = 0; ReqSigned = 0; ReqAddr = 0; ReqWData = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        model_mem[8'h18] = 8'h0F; model_mem[8'h19] = 8'hFB; model_mem[8'h1A] = 8'hEA; model_mem[8'h1B] = 8'h7D;
        model_mem[8'h1C] = 8'hEA; model_mem[8'h1D] = 8'hDB; model_mem[8'h1E] = 8'hEE; model_mem[8'h1F] = 8'hFF;
        model_mem[8'h0F] = 8'h0A;

        Reset = 0;
        #2 Reset = 1;
        repeat (3) @(negedge Clk);
        checkOutput("reset_ctrl", {58'd0, ReqReady, RespValid, RespError, MemoryRead, MemoryWrite, 1'b0}, 64'h20);
        checkOutput("reset_data", Address | WriteData | RespData, 64'd0);
        Reset = 0;

        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 64'h0FFBEA7DEADBEEFF, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h1C, 64'd0, 64'hFFFFFFFFEADBEEFF, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h1C, 64'd0, 64'h00000000EADBEEFF, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h1F, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h20, 64'h1234ABCD, 64'd0, 1'b0, 5, 1, 1, 64'hABCD000000000000});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'hABCD000000000000, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1, 1, 0, 0, 64'd0});
`ifdef LSU_ALIGN_CHECK_EN
        vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h21, 64'd0, 64'd0, 1'b1, 1, 0, 0, 64'd0});
`else
        vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h21, 64'd0, 64'h000000000000CD00, 1'b0, 3, 1, 0, 64'd0});
`endif
        vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h30, 64'h1122334455667788, 64'd0, 1'b0, 2, 0, 1, 64'h1122334455667788});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h30, 64'd0, 64'h0000000000001122, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h37, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 3, 1, 0, 64'd0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 64'h3F8, 64'h00000000000000EE, 64'd0, 1'b0, 5, 1, 1, 64'hEE00000000000000});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h55, 64'd0, 1'b1, 1, 0, 0, 64'd0});
        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset while the read-modify-write of a byte store is waiting for data.
        @(negedge Clk);
        ReqValid = 1; ReqWrite = 1; ReqSize = 2'd0; ReqSigned = 0; ReqAddr = 64'h08; ReqWData = 64'hEE;
        w0 = wr_count;
        @(posedge Clk);
        #1 ReqValid = 0;
        @(posedge Clk);
        #2 Reset = 1;
        #1;
        checkOutput("midreset_ctrl", {58'd0, ReqReady, RespValid, RespError, MemoryRead, MemoryWrite, 1'b0}, 64'h20);
        checkOutput("midreset_data", Address | WriteData | RespData, 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 0;
        repeat (4) @(negedge Clk);
        checkOutput("midreset_no_write", 64'(wr_count - w0), 64'd0);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, data, err, lat, nr, nw);
        checkOutput("midreset_reload", data, 64'h000000000000000A);

        // Randomized requests against the reference model.
        for (int t = 0; t < 150; t++) begin
            logic w, sg, ok;
            logic [1:0] sz;
            logic [63:0] a, wd, exp_data;
            int exp_lat;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'($urandom_range(0, 1030));
            if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
            ok = model_ok(sz, a);
            exp_data = (ok && !w) ? model_load(sz, sg, a) : 64'd0;
            exp_lat  = !ok ? 1 : (!w ? 3 : (sz == 2'd3 ? 2 : 5));
            applyStimulus(w, sz, sg, a, wd, data, err, lat, nr, nw);
            checkOutput($sformatf("rand%0d_data", t), data, exp_data);
            checkOutput($sformatf("rand%0d_err", t), {63'd0, err}, {63'd0, !ok});
            checkOutput($sformatf("rand%0d_lat", t), 64'(lat), 64'(exp_lat));
            checkOutput($sformatf("rand%0d_strobes", t), 64'(nr * 2 + nw),
                        64'(!ok ? 0 : (!w ? 2 : (sz == 2'd3 ? 1 : 3))));
            if (ok && w) model_store(sz, a, wd);
        end

        checkOutput("no_dual_strobe", {63'd0, both_seen}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
